uart_wb_bridge: RTL and testbench

Serial-to-Wishbone debug bridge: receives command frames on a UART line and issues single Wishbone initiator cycles to the SoC bus. It is the bus-master counterpart of the SoC's Wishbone-slave peripherals, including the UART, and is used for host-driven memory and peripheral access without the CPU. It contains its own UART receiver and transmitter, a command parser FSM and a Wishbone master port.

---
 rtl/uart_wb_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_wb_bridge.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_bridge.sv
// UART command-frame to Wishbone single-cycle master bridge with its own RX/TX.
// Optional ack timeout is enabled by defining UART_WB_BRIDGE_TIMEOUT_EN.
module uart_wb_bridge #(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int TIMEOUT    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        rx,
  output logic        tx,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [23:0] wb_adr,
  output logic [15:0] wb_o_dat,
  input  logic [15:0] wb_i_dat,
  input  logic        wb_ack,
  output logic        busy
);

  localparam int BIT_DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CW      = $clog2(BIT_DIV + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADR2, S_ADR1, S_ADR0, S_DAT1, S_DAT0, S_BUS, S_RESP} state_t;

  rx_state_t       r_rx_state;
  logic            r_rx_s1, r_rx_s2, r_rx_d;
  logic [CW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_byte;
  logic            r_rx_stb, r_rx_ferr;

  state_t          r_state;
  logic            r_busy, r_wr, r_cyc, r_we, r_more;
  logic [23:0]     r_adr;
  logic [15:0]     r_wdat;
  logic [7:0]      r_resp_lo;
  logic            r_tx;
  logic [8:0]      r_tx_sh;
  logic [CW-1:0]   r_tx_cnt;
  logic [3:0]      r_tx_bit;

  // Receiver: the previous synchronized level qualifies the falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= '0;
      r_rx_stb   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_d    <= r_rx_s2;
      r_rx_stb  <= 1'b0;
      r_rx_ferr <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (r_rx_d && !r_rx_s2) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= '0;
        end
        RX_START: if (r_rx_cnt == C_HALF) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_DATA: if (r_rx_cnt == C_LAST) begin
          r_rx_cnt  <= '0;
          r_rx_byte <= {r_rx_s2, r_rx_byte[7:1]};
          r_rx_bit  <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_STOP: if (r_rx_cnt == C_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_stb   <= r_rx_s2;
          r_rx_ferr  <= !r_rx_s2;
          r_rx_state <= RX_IDLE;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_to_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_to_cnt <= '0;
    else if (r_state == S_BUS) r_to_cnt <= r_to_cnt + 1'b1;
    else r_to_cnt <= '0;
  end

  assign w_to_hit = (r_to_cnt == TW'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  // Parser, bus master and transmitter share one state register so the
  // first start bit can be launched on the same edge that ends the bus cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_wr      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_more    <= 1'b0;
      r_resp_lo <= '0;
      r_tx      <= 1'b1;
      r_tx_sh   <= '1;
      r_tx_cnt  <= '0;
      r_tx_bit  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (r_rx_stb && (r_rx_byte == 8'h01 || r_rx_byte == 8'h02)) begin
          r_wr    <= (r_rx_byte == 8'h01);
          r_state <= S_ADR2;
          r_busy  <= 1'b1;
        end
        S_ADR2, S_ADR1, S_ADR0, S_DAT1, S_DAT0: begin
          if (r_rx_ferr) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_rx_stb) begin
            case (r_state)
              S_ADR2: begin r_adr[23:16] <= r_rx_byte; r_state <= S_ADR1; end
              S_ADR1: begin r_adr[15:8]  <= r_rx_byte; r_state <= S_ADR0; end
              S_ADR0: begin
                r_adr[7:0] <= r_rx_byte;
                if (r_wr) r_state <= S_DAT1;
                else begin
                  r_state <= S_BUS;
                  r_cyc   <= 1'b1;
                  r_we    <= 1'b0;
                end
              end
              S_DAT1: begin r_wdat[15:8] <= r_rx_byte; r_state <= S_DAT0; end
              S_DAT0: begin
                r_wdat[7:0] <= r_rx_byte;
                r_state     <= S_BUS;
                r_cyc       <= 1'b1;
                r_we        <= 1'b1;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_BUS: begin
          if (wb_ack) begin
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_state  <= S_RESP;
            r_tx     <= 1'b0;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            if (r_wr) begin
              r_tx_sh <= {1'b1, 8'hAA};
              r_more  <= 1'b0;
            end else begin
              r_tx_sh   <= {1'b1, wb_i_dat[15:8]};
              r_resp_lo <= wb_i_dat[7:0];
              r_more    <= 1'b1;
            end
          end
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
          else if (w_to_hit) begin
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_state  <= S_RESP;
            r_tx     <= 1'b0;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= {1'b1, 8'hEE};
            r_more   <= 1'b0;
          end
`endif
        end
        S_RESP: begin
          if (r_tx_cnt == C_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 4'd9) begin
              if (r_more) begin
                r_more   <= 1'b0;
                r_tx     <= 1'b0;
                r_tx_sh  <= {1'b1, r_resp_lo};
                r_tx_bit <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tx     <= r_tx_sh[0];
              r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
              r_tx_bit <= r_tx_bit + 4'd1;
            end
          end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx       = r_tx;
  assign wb_cyc   = r_cyc;
  assign wb_stb   = r_cyc;
  assign wb_we    = r_we;
  assign wb_adr   = r_adr;
  assign wb_o_dat = r_wdat;
  assign busy     = r_busy;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: UART frames in, Wishbone slave model, TX decoder,
// and a frame-level reference model for bus activity and response bytes.
module tb_uart_wb_bridge;
  localparam int CLOCK_FREQ = 1_600_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int TIMEOUT    = 16;
  localparam int BIT_DIV    = CLOCK_FREQ / BAUD_RATE;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        rx = 1'b1;
  logic        tx, wb_cyc, wb_stb, wb_we, busy, wb_ack;
  logic [23:0] wb_adr;
  logic [15:0] wb_o_dat;
  logic [15:0] rd_data = 16'h0;
  int          ack_delay = 0;
  logic        ack_force = 1'b0;
  int          cyc_cnt = 0;
  int          cyc_n = 0;

  int n_cmp = 0;
  int n_bad = 0;

  uart_wb_bridge #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(i_rst), .rx(rx), .tx(tx),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_o_dat(wb_o_dat), .wb_i_dat(rd_data), .wb_ack(wb_ack), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave: ack once the cycle has been open for ack_delay clocks (negative = never).
  always @(posedge clk) cyc_cnt <= wb_cyc ? cyc_cnt + 1 : 0;
  assign wb_ack = ack_force | (wb_cyc && ack_delay >= 0 && cyc_cnt >= ack_delay);

  // Bus monitor
  int          bus_cnt = 0, b_n = 0, fall_t = 0, busy_fall_t = 0;
  logic        b_we, b_stable, prev_cyc = 1'b0, prev_busy = 1'b0;
  logic [23:0] b_adr;
  logic [15:0] b_dat;
  always @(negedge clk) begin
    if (wb_cyc === 1'b1) begin
      if (!prev_cyc) begin
        b_adr = wb_adr; b_dat = wb_o_dat; b_we = wb_we; b_stable = 1'b1; b_n = 0;
      end else if (wb_adr !== b_adr || wb_o_dat !== b_dat || wb_we !== b_we) b_stable = 1'b0;
      if (wb_stb !== 1'b1) b_stable = 1'b0;
      b_n++;
    end else if (prev_cyc) begin
      bus_cnt++;
      fall_t = cyc_n;
    end
    if (prev_busy && busy === 1'b0) busy_fall_t = cyc_n;
    prev_cyc  = (wb_cyc === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  // TX decoder: records each byte, its stop bit and the cycle its start bit began.
  logic [7:0] tx_q[$];
  logic       tx_stop[$];
  int         tx_t[$];
  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        automatic int t0 = cyc_n;
        automatic logic [7:0] b = 8'h00;
        repeat (BIT_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_DIV) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT_DIV) @(negedge clk);
        tx_stop.push_back(tx);
        tx_q.push_back(b);
        tx_t.push_back(t0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_DIV) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // Sends one frame and checks bus access and response against the frame rules.
  task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [23:0] adr,
                          input logic [15:0] dat, input logic [15:0] rd, input int dly);
    int nb0 = bus_cnt;
    int nq0 = tx_q.size();
    int exp_n;
    logic [7:0] bytes[$];
    logic [7:0] exp_q[$];
    ack_delay = dly;
    rd_data   = rd;
    bytes = {cmd, adr[23:16], adr[15:8], adr[7:0]};
    if (cmd == 8'h01) begin
      bytes.push_back(dat[15:8]);
      bytes.push_back(dat[7:0]);
      exp_q = {8'hAA};
    end else exp_q = {rd[15:8], rd[7:0]};
    exp_n = dly + 1;
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    if (dly < 0 || dly > TIMEOUT - 1) begin
      exp_n = TIMEOUT;
      exp_q = {8'hEE};
    end
`endif
    foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    wait_idle({tag, "_idle"});
    chk({tag, "_buscnt"}, bus_cnt - nb0, 1);
    chk({tag, "_we"}, {31'd0, b_we}, {31'd0, cmd == 8'h01});
    chk({tag, "_adr"}, {8'd0, b_adr}, {8'd0, adr});
    if (cmd == 8'h01) chk({tag, "_odat"}, {16'd0, b_dat}, {16'd0, dat});
    chk({tag, "_ncyc"}, b_n, exp_n);
    chk({tag, "_stable"}, {31'd0, b_stable}, 32'd1);
    chk({tag, "_nresp"}, tx_q.size() - nq0, exp_q.size());
    if (tx_q.size() - nq0 == exp_q.size()) begin
      foreach (exp_q[i]) begin
        chk({tag, "_resp"}, {24'd0, tx_q[nq0 + i]}, {24'd0, exp_q[i]});
        chk({tag, "_stop"}, {31'd0, tx_stop[nq0 + i]}, 32'd1);
      end
      chk({tag, "_txstart"}, tx_t[nq0], fall_t);
      if (exp_q.size() == 2) chk({tag, "_gap"}, tx_t[nq0 + 1] - tx_t[nq0], 10 * BIT_DIV);
      chk({tag, "_busyfall"}, busy_fall_t, tx_t[nq0] + 10 * BIT_DIV * exp_q.size());
    end
  endtask

  initial begin
    int nb0, nq0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb}, 32'd0);
    chk("rst_we", {31'd0, wb_we}, 32'd0);
    chk("rst_adr", {8'd0, wb_adr}, 32'd0);
    chk("rst_odat", {16'd0, wb_o_dat}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    i_rst = 1'b0;
    repeat (BIT_DIV) @(negedge clk);

    // Ack while no cycle is open has no effect.
    nb0 = bus_cnt;
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_ack_busy", {31'd0, busy}, 32'd0);
    chk("spur_ack_bus", bus_cnt - nb0, 0);

    do_frame("wr", 8'h01, 24'h000002, 16'h1234, 16'h0000, 3);
    do_frame("rd", 8'h02, 24'h000001, 16'h0000, 16'hBEEF, 0);

    // Framing-error command byte is discarded.
    send_byte(8'h01, 1'b0);
    repeat (BIT_DIV) @(negedge clk);
    chk("ferr_busy", {31'd0, busy}, 32'd0);
    do_frame("ferr_rd", 8'h02, 24'h123456, 16'h0000, 16'hA55A, 1);

    // Command codes inside a frame are plain data.
    do_frame("cmd_as_data", 8'h01, 24'h010201, 16'h0102, 16'h0000, 2);

    // Reset in the middle of the second address byte aborts the frame.
    nb0 = bus_cnt;
    nq0 = tx_q.size();
    send_byte(8'h7F, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h5A, 1'b1);
    rx = 1'b0;
    repeat (BIT_DIV * 5 / 2) @(negedge clk);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("mid_rst_we", {31'd0, wb_we}, 32'd0);
    chk("mid_rst_adr", {8'd0, wb_adr}, 32'd0);
    chk("mid_rst_odat", {16'd0, wb_o_dat}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    repeat (BIT_DIV * 20) @(negedge clk);
    chk("mid_rst_nobus", bus_cnt - nb0, 0);
    chk("mid_rst_noresp", tx_q.size() - nq0, 0);
    chk("mid_rst_idle", {31'd0, busy}, 32'd0);
    do_frame("post_rst_wr", 8'h01, 24'hC0FFEE, 16'hD00D, 16'h0000, 0);

    // A short low glitch must not be taken as a start bit.
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    do_frame("glitch_rd", 8'h02, 24'h00ABCD, 16'h0000, 16'h1357, 2);

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    do_frame("timeout", 8'h02, 24'h000010, 16'h0000, 16'h4242, -1);
    do_frame("ack_at_limit", 8'h01, 24'h000020, 16'h7777, 16'h0000, TIMEOUT - 1);
`endif

    for (int k = 0; k < 6; k++) begin
      automatic logic [7:0]  c = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      automatic logic [23:0] a = 24'($urandom);
      automatic logic [15:0] d = 16'($urandom);
      automatic logic [15:0] r = 16'($urandom);
      do_frame($sformatf("rand%0d", k), c, a, d, r, int'($urandom_range(0, 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
